// File: rtl/pipeline_hazard_controller_if.sv
// Stall/flush control bundle between the hazard controller and the pipeline.
// master: controller side (hazard inputs in, enables/flushes out).
// slave: pipeline side (drives hazard inputs, consumes enables/flushes).
interface pipeline_hazard_controller_if #(
  parameter int REG_IDX_W = 5
);
  logic [REG_IDX_W-1:0] id_rs1;
  logic [REG_IDX_W-1:0] id_rs2;
  logic                 id_r_read1;
  logic                 id_r_read2;
  logic                 id_halt;
  logic                 ex_mem_read;
  logic [REG_IDX_W-1:0] ex_rd;
  logic                 ex_branch_taken;
  logic                 icache_miss;
  logic                 dcache_stall;
  logic                 pc_en;
  logic                 ifid_en;
  logic                 idex_en;
  logic                 exmem_en;
  logic                 memwb_en;
  logic                 ifid_flush;
  logic                 idex_flush;
  logic                 exmem_flush;
  logic                 halted;

  modport master (
    input  id_rs1, id_rs2, id_r_read1, id_r_read2, id_halt,
    input  ex_mem_read, ex_rd, ex_branch_taken, icache_miss, dcache_stall,
    output pc_en, ifid_en, idex_en, exmem_en, memwb_en,
    output ifid_flush, idex_flush, exmem_flush, halted
  );

  modport slave (
    output id_rs1, id_rs2, id_r_read1, id_r_read2, id_halt,
    output ex_mem_read, ex_rd, ex_branch_taken, icache_miss, dcache_stall,
    input  pc_en, ifid_en, idex_en, exmem_en, memwb_en,
    input  ifid_flush, idex_flush, exmem_flush, halted
  );
endinterface

// File: rtl/pipeline_hazard_controller.sv
// Purpose: stall/flush sequencer for IF/ID, ID/EX, EX/MEM, MEM/WB plus halt drain.
// Latency: enables/flushes are combinational from state, cnt and hazard inputs.
// Backpressure: dcache_stall freezes every stage and the FSM until it drops.
// Ports: clk, rst (async, active-high); bus (master modport) carries the ID/EX
//   hazard sources, cache status, per-stage en/flush, pc_en and halted.
module pipeline_hazard_controller #(
  parameter int REG_IDX_W        = 5,
  parameter int LOAD_USE_BUBBLES = 1,
  parameter int DRAIN_CYCLES     = 3
) (
  input  logic                          clk,
  input  logic                          rst,
  pipeline_hazard_controller_if.master  bus
);

  typedef enum logic [1:0] {RUN, LU_STALL, DRAIN, HALTED} state_t;

  // First bubble is the detection cycle itself, so LU_STALL counts the rest.
  localparam logic [1:0] LU_INIT = (LOAD_USE_BUBBLES > 1) ? 2'(LOAD_USE_BUBBLES - 2) : 2'd0;
  localparam logic [1:0] DR_INIT = 2'(DRAIN_CYCLES - 1);

  state_t state_q, state_d;
  logic [1:0] cnt_q, cnt_d;

  logic [REG_IDX_W-1:0] rs1, rs2, rd;
  logic hazard;

  logic pc_en, ifid_en, idex_en, exmem_en, memwb_en;
  logic ifid_flush, idex_flush, exmem_flush, halted;

  assign rs1 = bus.id_rs1;
  assign rs2 = bus.id_rs2;
  assign rd  = bus.ex_rd;

  // r0 is hardwired zero, so a load targeting it never creates a dependency.
  assign hazard = bus.ex_mem_read && (rd != '0) &&
                  ((bus.id_r_read1 && (rs1 == rd)) || (bus.id_r_read2 && (rs2 == rd)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RUN;
      cnt_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    pc_en       = 1'b0;
    ifid_en     = 1'b0;
    idex_en     = 1'b0;
    exmem_en    = 1'b0;
    memwb_en    = 1'b0;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    exmem_flush = 1'b0;
    halted      = 1'b0;

    if (rst) begin
      // everything held low while in reset
    end else if (state_q == HALTED) begin
      halted = 1'b1;
    end else if (bus.dcache_stall) begin
      // full freeze: state and countdown hold
    end else if (bus.ex_branch_taken && (state_q == RUN || state_q == LU_STALL)) begin
      // Wrong-path IF/ID and ID/EX contents are squashed, including any halt.
      {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = 5'b11111;
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
      state_d    = RUN;
      cnt_d      = 2'd0;
    end else if ((state_q == RUN && hazard) || state_q == LU_STALL) begin
      // Hold PC and IF/ID, inject a bubble into ID/EX, let older work drain.
      idex_en    = 1'b1;
      idex_flush = 1'b1;
      exmem_en   = 1'b1;
      memwb_en   = 1'b1;
      if (state_q == RUN) begin
        if (LOAD_USE_BUBBLES > 1) begin
          state_d = LU_STALL;
          cnt_d   = LU_INIT;
        end
      end else if (cnt_q == 2'd0) begin
        state_d = RUN;
      end else begin
        cnt_d = cnt_q - 2'd1;
      end
    end else if (state_q == RUN && bus.id_halt) begin
      // The halt itself moves into EX; nothing younger is fetched.
      idex_en  = 1'b1;
      exmem_en = 1'b1;
      memwb_en = 1'b1;
      state_d  = DRAIN;
      cnt_d    = DR_INIT;
    end else if (state_q == DRAIN) begin
      idex_en    = 1'b1;
      idex_flush = 1'b1;
      exmem_en   = 1'b1;
      memwb_en   = 1'b1;
      if (cnt_q == 2'd0) begin
        state_d = HALTED;
      end else begin
        cnt_d = cnt_q - 2'd1;
      end
    end else if (bus.icache_miss) begin
      // No valid fetch: hold PC, load a bubble into IF/ID.
      {ifid_en, idex_en, exmem_en, memwb_en} = 4'b1111;
      ifid_flush = 1'b1;
    end else begin
      {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = 5'b11111;
    end
  end

  assign bus.pc_en       = pc_en;
  assign bus.ifid_en     = ifid_en;
  assign bus.idex_en     = idex_en;
  assign bus.exmem_en    = exmem_en;
  assign bus.memwb_en    = memwb_en;
  assign bus.ifid_flush  = ifid_flush;
  assign bus.idex_flush  = idex_flush;
  assign bus.exmem_flush = exmem_flush;
  assign bus.halted      = halted;

endmodule

// File: doc/pipeline_hazard_controller.md
Name: pipeline_hazard_controller

Overview:
- Central stall/flush sequencer for the four control pipeline register stages: IF/ID, ID/EX, EX/MEM and MEM/WB.
- Detects load-use hazards, instruction-cache misses, data-cache stalls, taken branches/jumps and halt.
- Drives a per-stage load enable and a per-stage bubble (flush) request.
- Owns the halt-drain state machine that quiesces the core.

Parameters:
- REG_IDX_W, 5, width of scalar register index.
- LOAD_USE_BUBBLES, 1, bubbles inserted per load-use hazard (1..3).
- DRAIN_CYCLES, 3, cycles after halt reaches ID before the core reports halted.

Ports:
- clk  input  1  core clock
- rst  input  1  reset; one clock; reset is asynchronous and active-high
- id_rs1  input  REG_IDX_W  scalar read reg 1 of instruction in ID
- id_rs2  input  REG_IDX_W  scalar read reg 2 of instruction in ID
- id_r_read1  input  1  ID instruction actually reads id_rs1
- id_r_read2  input  1  ID instruction actually reads id_rs2
- id_halt  input  1  halt instruction decoded in ID
- ex_mem_read  input  1  instruction in EX is a load
- ex_rd  input  REG_IDX_W  destination reg of instruction in EX
- ex_branch_taken  input  1  branch/jump resolved taken in EX
- icache_miss  input  1  fetch not valid this cycle
- dcache_stall  input  1  data cache cannot complete MEM access this cycle
- pc_en  output  1  PC may advance
- ifid_en, idex_en, exmem_en, memwb_en  output  1 each  stage register load enable
- ifid_flush, idex_flush, exmem_flush  output  1 each  stage register loads bubble (all control fields zero)
- halted  output  1  core fully drained

Behaviour:
- State register: RUN, LU_STALL, DRAIN, HALTED. Counter cnt is 2 bits and is used by LU_STALL and DRAIN.
- While rst is high, all outputs are 0, state=RUN and cnt=0. After rst falls, outputs follow the rules below from the first cycle.
- Outputs are combinational from state, cnt and inputs. The flush for a stage takes effect at the next edge; flush has priority over en inside the stage register.
- Rules are applied in priority order, first match wins:
  1. dcache_stall, any state except HALTED:
     - All en=0, all flush=0, pc_en=0.
     - State and cnt hold, including a DRAIN countdown.
     - Load-use and branch detection are suppressed this cycle. The inputs are re-evaluated once the stall drops.
  2. ex_branch_taken in RUN or LU_STALL:
     - pc_en=1, all en=1, ifid_flush=1, idex_flush=1.
     - Any load-use stall is abandoned and state goes to RUN.
     - A simultaneous id_halt is ignored, because the halt is on the wrong path.
  3. Load-use hazard in RUN. Hazard = ex_mem_read & ex_rd!=0 & ((id_r_read1 & id_rs1==ex_rd) | (id_r_read2 & id_rs2==ex_rd)).
     - pc_en=0, ifid_en=0, idex_flush=1, exmem_en=memwb_en=1.
     - If LOAD_USE_BUBBLES>1: go to LU_STALL with cnt=LOAD_USE_BUBBLES-2.
  4. LU_STALL:
     - Same outputs as rule 3. The hazard is not re-checked.
     - cnt==0 → RUN; otherwise decrement cnt.
  5. id_halt in RUN:
     - pc_en=0, ifid_en=0, idex_en=1, idex_flush=0, exmem_en=memwb_en=1.
     - Go to DRAIN with cnt=DRAIN_CYCLES-1.
  6. DRAIN:
     - pc_en=0, ifid_en=0, idex_flush=1, exmem_en=memwb_en=1.
     - cnt==0 → HALTED; otherwise decrement.
     - ex_branch_taken and icache_miss are ignored in DRAIN.
  7. icache_miss in RUN:
     - pc_en=0, ifid_flush=1, other en=1.
  8. RUN default: all en=1, flush=0, pc_en=1.
- HALTED: all en=0, flush=0, halted=1, and dcache_stall is ignored. The only exit is rst.
- Reset mid-stall or mid-drain returns to RUN immediately.

Test Plan:
- Load-use: ex_mem_read=1, ex_rd=7, id_rs1=7, id_r_read1=1 → exactly one cycle with pc_en=0, ifid_en=0, idex_flush=1, then normal. With LOAD_USE_BUBBLES=3 → three such cycles.
- No false hazard: ex_rd=0 matching id_rs1=0, or ex_rd=7 with id_r_read1=0 → pc_en=1, idex_flush=0.
- Branch with hazard: ex_branch_taken=1 together with a load-use hazard on r3 → pc_en=1, ifid_flush=idex_flush=1, state RUN next cycle.
- Stall priority: dcache_stall high for 4 cycles in the middle of LU_STALL (LOAD_USE_BUBBLES=3, cnt=1) → all en=0 for 4 cycles; after release the remaining stall cycles complete with the counter intact.
- Halt: id_halt=1 for one cycle (DRAIN_CYCLES=3) → pc_en=0 from that cycle, halted=1 exactly 4 cycles later and stays high. Pulsing rst high for 1 cycle returns to RUN with halted=0.
- icache_miss for 2 cycles in RUN → pc_en=0, ifid_flush=1 for 2 cycles, memwb_en=1 throughout.
